// File: rtl/alu_sequencer.sv
// Two-entry instruction FIFO feeding an IDLE/ISSUE/HALT sequencer that drives ALU datapath controls.
// Optional skip-on-zero (SKZ) support is compiled in when ALU_SEQUENCER_SKZ_EN is defined.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic        instr_ready,
    input  logic        zero,
    input  logic        resume,
    output logic [3:0]  read_reg1,
    output logic [3:0]  read_reg2,
    output logic [3:0]  write_reg,
    output logic [2:0]  alu_ctrl,
    output logic        reg_write,
    output logic        halted,
    output logic [7:0]  issue_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [15:0] fifo_mem [0:1];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  fifo_count;
    logic [1:0]  fifo_count_next;
    logic        push;
    logic        pop;
    logic [15:0] head;
    logic        head_is_alu;
    logic        head_is_halt;
    logic        skip_now;
    logic        do_write;
    logic        zero_flag;

    assign head         = fifo_mem[rd_ptr];
    assign head_is_alu  = ~head[15];
    assign head_is_halt = head[15] && (head[14:12] == OP_HALT);
    assign instr_ready  = (fifo_count != 2'd2);
    assign push         = instr_valid && instr_ready;
    assign pop          = (state == ST_ISSUE);
    assign do_write     = (state == ST_ISSUE) && head_is_alu && !skip_now;

    // Datapath controls are gated so they only carry head fields during a real write-back.
    assign reg_write = do_write;
    assign write_reg = do_write ? head[11:8]  : 4'd0;
    assign read_reg1 = do_write ? head[7:4]   : 4'd0;
    assign read_reg2 = do_write ? head[3:0]   : 4'd0;
    assign alu_ctrl  = do_write ? head[14:12] : 3'd0;
    assign halted    = (state == ST_HALT);

`ifdef ALU_SEQUENCER_SKZ_EN
    logic skip_pending;
    logic head_is_skz;

    assign head_is_skz = head[15] && (head[14:12] == OP_SKZ);
    assign skip_now    = skip_pending;

    // Arm on a taken SKZ; the next instruction popped (whatever it is) consumes the skip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_pending <= 1'b0;
        end else if (state == ST_ISSUE) begin
            if (skip_pending) begin
                skip_pending <= 1'b0;
            end else if (head_is_skz && zero_flag) begin
                skip_pending <= 1'b1;
            end else begin
                skip_pending <= 1'b0;
            end
        end else begin
            skip_pending <= skip_pending;
        end
    end
`else
    assign skip_now = 1'b0;
`endif

    // Occupancy after this edge; a pop from a full FIFO frees space only from the next cycle.
    always_comb begin
        fifo_count_next = fifo_count;
        case ({push, pop})
            2'b10:   fifo_count_next = fifo_count + 2'd1;
            2'b01:   fifo_count_next = fifo_count - 2'd1;
            default: fifo_count_next = fifo_count;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (fifo_count != 2'd0) begin
                    state_next = ST_ISSUE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (head_is_halt && !skip_now) begin
                    state_next = ST_HALT;
                end else if (fifo_count_next != 2'd0) begin
                    state_next = ST_ISSUE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_HALT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= 16'd0;
            fifo_mem[1] <= 16'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= instr_data;
                wr_ptr           <= ~wr_ptr;
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end else begin
                rd_ptr <= rd_ptr;
            end
            fifo_count <= fifo_count_next;
        end
    end

    // Sequencer state, zero flag capture and issue counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            zero_flag   <= 1'b0;
            issue_count <= 8'd0;
        end else begin
            state <= state_next;
            if (do_write) begin
                zero_flag   <= zero;
                issue_count <= issue_count + 8'd1;
            end else begin
                zero_flag   <= zero_flag;
                issue_count <= issue_count;
            end
        end
    end

endmodule
